lc3_alu_sequencer: RTL and testbench

Multi-cycle execute controller that drives the LC-3 eight-entry, 16-bit register file from the initiator side. It accepts one operate-class instruction (ADD, AND, NOT) per handshake and drives the source selects, then consumes the two read ports. It computes the result and issues a single write-enable pulse with the destination select and data, updating the NZP condition codes. It sits between instruction fetch and the register file, and is the only writer of the register file in the datapath.

---
 rtl/lc3_pkg.sv | 32 +++
 rtl/lc3_op_alu.sv | 37 +++
 rtl/lc3_alu_sequencer.sv | 107 ++++++++++
 tb/tb_lc3_alu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// ============================================================================
// lc3_pkg
// Shared opcodes, condition-code encodings, FSM states and helpers for the
// LC-3 operate-class execute path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lc3_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_op_alu.sv
// ============================================================================
// lc3_op_alu
// Combinational ADD/AND/NOT unit producing the result and its NZP code.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc3_op_alu
    import lc3_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] Ra,
    input  logic [15:0] operand,
    output logic [15:0] result,
    output logic [2:0]  nzp
);

    always_comb begin
        result = 16'h0000;
        case (op)
            OP_ADD:  result = Ra + operand;
            OP_AND:  result = Ra & operand;
            OP_NOT:  result = ~Ra;
            default: result = 16'h0000;
        endcase

        if (result[15])
            nzp = NZP_N;
        else if (result == 16'h0000)
            nzp = NZP_Z;
        else
            nzp = NZP_P;
    end

endmodule

`default_nettype wire

// File: rtl/lc3_alu_sequencer.sv
// ============================================================================
// lc3_alu_sequencer
// Four-state execute controller: latch instruction, read operands, compute,
// write back with condition-code update.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc3_alu_sequencer
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    input  logic [15:0] Ra,
    input  logic [15:0] Rb,
    output logic [2:0]  DR,
    output logic        regWE,
    output logic [15:0] b,
    output logic [2:0]  nzp,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr;
    logic [15:0] r_b;
    logic [2:0]  r_nzp;
    logic        r_err;

    logic [3:0]  w_op;
    logic        w_legal;
    logic        w_accept;
    logic [15:0] w_operand;
    logic [15:0] w_result;
    logic [2:0]  w_alu_nzp;

    assign w_op      = r_instr[15:12];
    assign w_legal   = (w_op == OP_ADD) || (w_op == OP_AND) || (w_op == OP_NOT);
    assign w_accept  = instr_valid && (r_state == ST_IDLE);
    assign w_operand = r_instr[5] ? sext5(r_instr[4:0]) : Rb;

    lc3_op_alu u_alu (
        .op      (w_op),
        .Ra      (Ra),
        .operand (w_operand),
        .result  (w_result),
        .nzp     (w_alu_nzp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_instr <= 16'h0000;
            r_b     <= 16'h0000;
            r_nzp   <= NZP_Z;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == ST_READ) && !w_legal;
            if (w_accept)
                r_instr <= instr;
            // Result and codes land together so both are valid for the whole WB cycle.
            if (r_state == ST_EXEC) begin
                r_b   <= w_result;
                r_nzp <= w_alu_nzp;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        regWE       = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    w_next = ST_READ;
            end
            ST_READ: w_next = w_legal ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_next = ST_WB;
            ST_WB: begin
                regWE  = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign SR1 = r_instr[8:6];
    assign SR2 = r_instr[2:0];
    assign DR  = r_instr[11:9];
    assign b   = r_b;
    assign nzp = r_nzp;
    assign err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lc3_alu_sequencer.sv
// ============================================================================
// tb_lc3_alu_sequencer
// Scoreboard bench with a behavioural register-file model for lc3_alu_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lc3_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  SR1, SR2, DR;
    logic [15:0] Ra, Rb, b;
    logic        regWE, done, err;
    logic [2:0]  nzp;

    lc3_alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .SR1         (SR1),
        .SR2         (SR2),
        .Ra          (Ra),
        .Rb          (Rb),
        .DR          (DR),
        .regWE       (regWE),
        .b           (b),
        .nzp         (nzp),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT; preload port lets the bench seed values.
    logic [15:0] rf [8];
    logic        pl_en;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;

    assign Ra = rf[SR1];
    assign Rb = rf[SR2];

    always @(posedge clk) begin
        if (regWE)
            rf[DR] <= b;
        else if (pl_en)
            rf[pl_idx] <= pl_val;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [2:0]  dr;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] b;
        logic [2:0]  nzp;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    int   mrf [8];
    int   mnzp = 2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Architectural model: integer arithmetic on a shadow register file.
    task automatic predict(input logic [15:0] ins, input int acc, output exp_t e);
        int op, a, opnd, imm, res;
        op  = int'(ins[15:12]);
        a   = mrf[ins[8:6]];
        imm = int'(ins[4:0]);
        if (imm > 15) imm = imm - 32;
        opnd = ins[5] ? (imm + 65536) % 65536 : mrf[ins[2:0]];
        e.is_err = 1'b0;
        e.dr  = ins[11:9];
        e.s1  = ins[8:6];
        e.s2  = ins[2:0];
        e.acc = acc;
        if (op == 1)      res = (a + opnd) % 65536;
        else if (op == 5) res = a & opnd;
        else if (op == 9) res = 65535 - a;
        else begin
            e.is_err = 1'b1;
            res = 0;
        end
        if (!e.is_err) begin
            mrf[ins[11:9]] = res;
            mnzp = (res > 32767) ? 4 : ((res == 0) ? 2 : 1);
        end
        e.b   = 16'(res);
        e.nzp = 3'(mnzp);
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        mrf[idx] = int'(val);
    endtask

    task automatic issue(input logic [15:0] ins, input bit push, output int acc);
        exp_t e;
        bit   got;
        got = 1'b0;
        acc = -1;
        instr = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                got = 1'b1;
                acc = cyc + 1;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
        end else begin
            if (push) begin
                predict(ins, acc, e);
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (done || err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("err_pulse", {31'd0, err}, {31'd0, e.is_err});
                    chk("done_pulse", {31'd0, done}, {31'd0, !e.is_err});
                    chk("regWE", {31'd0, regWE}, {31'd0, !e.is_err});
                    chk("latency", 32'(cyc - e.acc), e.is_err ? 32'd1 : 32'd2);
                    chk("nzp", {29'd0, nzp}, {29'd0, e.nzp});
                    chk("SR1", {29'd0, SR1}, {29'd0, e.s1});
                    if (!e.is_err) begin
                        chk("DR", {29'd0, DR}, {29'd0, e.dr});
                        chk("SR2", {29'd0, SR2}, {29'd0, e.s2});
                        chk("b", {16'd0, b}, {16'd0, e.b});
                    end
                end
            end else begin
                if (regWE)
                    chk("regWE_without_done", 32'd1, 32'd0);
                if (q.size() > 0 && cyc > q[0].acc + 2) begin
                    chk("response_timeout", 32'(cyc - q[0].acc), 32'd2);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, a4, a5;
        logic [15:0] ins;
        int sel;
        reset = 1'b1;
        instr = 16'h0000;
        instr_valid = 1'b0;
        pl_en = 1'b0;
        pl_idx = 3'd0;
        pl_val = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_regWE", {31'd0, regWE}, 32'd0);
        chk("rst_nzp", {29'd0, nzp}, 32'd2);
        chk("rst_b", {16'd0, b}, 32'd0);
        chk("rst_sel", {23'd0, SR1, SR2, DR}, 32'd0);
        chk("rst_pulses", {30'd0, done, err}, 32'd0);

        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
        preload(3'd1, 16'd5);
        preload(3'd2, 16'd7);

        // ADD R1,R1,R2 : 5 + 7
        issue(16'h1242, 1'b1, a0);
        @(negedge clk);
        chk("read_SR1", {29'd0, SR1}, 32'd1);
        chk("read_SR2", {29'd0, SR2}, 32'd2);
        wait_idle();

        preload(3'd1, 16'h8001);
        issue(16'h5A7F, 1'b1, a0);
        wait_idle();

        preload(3'd1, 16'hFFFF);
        issue(16'h967F, 1'b1, a0);
        wait_idle();

        // ADD R4,R1,#1 with 7FFF wraps to 8000
        preload(3'd1, 16'h7FFF);
        issue(16'h1861, 1'b1, a0);
        wait_idle();

        // Illegal opcode then immediate re-accept
        issue(16'h0000, 1'b1, a1);
        issue(16'h1242, 1'b1, a2);
        chk("illegal_reaccept", 32'(a2 - a1), 32'd2);
        wait_idle();

        // Reset while in EXEC
        issue(16'h1242, 1'b0, a3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstx_regWE", {31'd0, regWE}, 32'd0);
        chk("rstx_ready", {31'd0, instr_ready}, 32'd1);
        chk("rstx_b", {16'd0, b}, 32'd0);
        chk("rstx_nzp", {29'd0, nzp}, 32'd2);
        mnzp = 2;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        issue(16'h1242, 1'b1, a0);
        wait_idle();

        // Back-to-back with valid held: dependent chain through R1
        issue(16'h1242, 1'b1, a3);
        issue(16'h5A7F, 1'b1, a4);
        issue(16'h967F, 1'b1, a5);
        chk("b2b_gap1", 32'(a4 - a3), 32'd4);
        chk("b2b_gap2", 32'(a5 - a4), 32'd4);
        wait_idle();

        for (int n = 0; n < 150; n++) begin
            ins = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 3)      ins[15:12] = 4'b0001;
            else if (sel < 6) ins[15:12] = 4'b0101;
            else if (sel < 8) ins[15:12] = 4'b1001;
            else begin
                while (ins[15:12] == 4'b0001 || ins[15:12] == 4'b0101 || ins[15:12] == 4'b1001)
                    ins[15:12] = 4'($urandom);
            end
            issue(ins, 1'b1, a0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (4) @(posedge clk);
        if (q.size() != 0)
            chk("queue_drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
